fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter THREADS_PER_BLOCK, default 4: number of threads served, one fetch channel each.
REQ-002 SHALL have parameter PROGRAM_MEM_ADDR_BITS, default 8: program memory address width (matches PC width).
REQ-003 SHALL have parameter PROGRAM_MEM_DATA_BITS, default 16: instruction width.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port core_state  input  3 x THREADS_PER_BLOCK  per-thread scheduler state (FETCH=001, DECODE=010).
REQ-007 SHALL have port current_pc  input  8 x THREADS_PER_BLOCK  per-thread PC to fetch.
REQ-008 SHALL have port fetcher_state  output  3 x THREADS_PER_BLOCK  per-thread state: IDLE=000, FETCHING=001, FETCHED=010.
REQ-009 SHALL have port instruction  output  PROGRAM_MEM_DATA_BITS x THREADS_PER_BLOCK  latched instruction per thread.
REQ-010 SHALL have port mem_read_valid  output  1  program-memory read request, registered.
REQ-011 SHALL have port mem_read_address  output  PROGRAM_MEM_ADDR_BITS  request address, registered.
REQ-012 SHALL have port mem_read_ready  input  1  memory response strobe, data valid this cycle.
REQ-013 SHALL have port mem_read_data  input  PROGRAM_MEM_DATA_BITS  response data.

Function
REQ-014 Per thread: IDLE -> FETCHING on the edge where core_state==FETCH.
REQ-015 Per thread: FETCHED -> IDLE on the edge where core_state==DECODE; FETCHED SHALL otherwise hold.
REQ-016 At most one memory request SHALL be outstanding at a time; one shared memory port.
REQ-017 When no request is outstanding and mem_read_valid is low, a round-robin arbiter SHALL grant one FETCHING thread, searching from the thread after the last grant.
REQ-018 On grant edge: mem_read_valid<=1 and mem_read_address<=current_pc[granted]; both SHALL stay stable until mem_read_ready is sampled high.
REQ-019 On the edge sampling mem_read_valid&&mem_read_ready: mem_read_valid<=0, instruction[granted]<=mem_read_data, fetcher_state[granted]<=FETCHED.
REQ-020 Coalescing: on that same edge, every other FETCHING thread whose current_pc equals mem_read_address SHALL also latch the data and go FETCHED.
REQ-021 mem_read_valid SHALL be low for at least one cycle between consecutive requests.
REQ-022 Minimum latency: core_state=FETCH sampled at edge N -> FETCHING at N, valid at N+1, FETCHED at N+2 if ready is high in cycle N+1.
REQ-023 A FETCHING thread not granted whose core_state leaves FETCH (e.g. DONE) SHALL return to IDLE and not be granted.
REQ-024 A granted request whose thread leaves FETCH SHALL still complete on the memory port; that thread SHALL go IDLE, not FETCHED, and instruction SHALL not update.
REQ-025 mem_read_ready while mem_read_valid is low SHALL be ignored.
REQ-026 Undefined fetcher_state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-027 While reset is low: all fetcher_state=IDLE, all instruction=0, mem_read_valid=0, mem_read_address=0, arbiter pointer so thread 0 has first priority, no request outstanding.
REQ-028 Reset asserted mid-request SHALL abandon the request immediately; no response SHALL be captured after release until a new grant.

Structure
REQ-029 Core-state and fetcher-state encodings and the PC and instruction widths SHALL live in shared package gpu_pkg.
REQ-030 Arbitration SHALL be one sub-module, rr_arbiter, parameterized by requester count, with a registered last-grant pointer.

Verification
REQ-031 Single thread: core_state[0]=FETCH, pc=0x05, memory ready one cycle after valid, data 0x1234 -> address 0x05, instruction[0]=0x1234, FETCHED within 3 edges; then DECODE -> IDLE.
REQ-032 Four threads FETCH simultaneously, PCs 0x10/0x11/0x12/0x13, ready delay 2 -> grants in order 0,1,2,3, valid low one cycle between requests, each instruction matches its PC.
REQ-033 Coalescing: all four threads pc=0x20 -> exactly one request (address 0x20), all four FETCHED on the same edge with identical data.
REQ-034 Abort: thread 1 granted, core_state[1]->DONE before ready -> request completes, thread 1 IDLE, instruction[1] unchanged; ungranted thread 2 -> DONE goes IDLE and is never requested.
REQ-035 Reset low during pending request with ready stuck low -> valid=0 immediately; after release, a late ready pulse changes no outputs.
REQ-036 Round-robin fairness: threads 0 and 3 re-request continuously -> grants alternate 0,3,0,3, with no starvation.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared encodings and widths for the GPU fetch path.
//   CORE_*      : scheduler (core) state encodings seen on core_state
//   fetcher_state_e : per-thread fetcher state encodings on fetcher_state
//   PC_BITS / INSTR_BITS : program counter and instruction widths
package gpu_pkg;

    localparam int PC_BITS    = 8;
    localparam int INSTR_BITS = 16;

    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;
    localparam logic [2:0] CORE_DONE   = 3'b111;

    typedef enum logic [2:0] {
        FETCHER_IDLE     = 3'b000,
        FETCHER_FETCHING = 3'b001,
        FETCHER_FETCHED  = 3'b010
    } fetcher_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered last-grant pointer.
//   clk, rst_n    : clock, asynchronous active-low reset
//   req_i         : one request bit per requester
//   en_i          : a grant may be issued this cycle (pointer advances only then)
//   gnt_valid_o   : some requester is selected (combinational)
//   gnt_idx_o     : index of the selected requester (combinational)
// The search starts at the requester after the last grant; after reset the
// pointer sits on N-1 so requester 0 has first priority.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    input  logic          en_i,
    output logic          gnt_valid_o,
    output logic [IW-1:0] gnt_idx_o
);

    logic [IW-1:0] last_q;
    logic [IW-1:0] last_d;

    // Rotating priority search and pointer next-state.
    always_comb begin
        int          cand;
        logic [IW-1:0] cidx;
        gnt_valid_o = 1'b0;
        gnt_idx_o   = last_q;
        cand        = 0;
        cidx        = '0;
        for (int i = 1; i <= N; i++) begin
            cand = (int'(last_q) + i) % N;
            cidx = IW'(cand);
            if (!gnt_valid_o && req_i[cidx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = cidx;
            end else begin
                gnt_valid_o = gnt_valid_o;
            end
        end
        if (en_i && gnt_valid_o) begin
            last_d = gnt_idx_o;
        end else begin
            last_d = last_q;
        end
    end

    // Last-grant pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IW'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Multi-thread instruction fetcher sharing one program-memory read port.
//   clk              : clock, all state on rising edge
//   reset            : asynchronous active-low reset
//   core_state       : per-thread scheduler state, 3 bits each
//   current_pc       : per-thread PC to fetch
//   fetcher_state    : per-thread fetcher state (IDLE/FETCHING/FETCHED)
//   instruction      : per-thread latched instruction
//   mem_read_valid   : registered memory read request
//   mem_read_address : registered request address
//   mem_read_ready   : memory response strobe (data valid this cycle)
//   mem_read_data    : memory response data
// One request is outstanding at a time. A response is also delivered to every
// other fetching thread whose PC matches the request address.
module fetch_unit
    import gpu_pkg::*;
#(
    parameter int THREADS_PER_BLOCK     = 4,
    parameter int PROGRAM_MEM_ADDR_BITS = PC_BITS,
    parameter int PROGRAM_MEM_DATA_BITS = INSTR_BITS
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic [3*THREADS_PER_BLOCK-1:0]                     core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS*THREADS_PER_BLOCK-1:0] current_pc,
    output logic [3*THREADS_PER_BLOCK-1:0]                     fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS*THREADS_PER_BLOCK-1:0] instruction,
    output logic                                               mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]                   mem_read_address,
    input  logic                                               mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0]                   mem_read_data
);

    localparam int T  = THREADS_PER_BLOCK;
    localparam int AW = PROGRAM_MEM_ADDR_BITS;
    localparam int DW = PROGRAM_MEM_DATA_BITS;
    localparam int IW = (T > 1) ? $clog2(T) : 1;

    logic [2:0]     core_s  [T];
    logic [AW-1:0]  pc_s    [T];
    fetcher_state_e fstate_q[T];
    fetcher_state_e fstate_d[T];
    logic [DW-1:0]  instr_q [T];
    logic [DW-1:0]  instr_d [T];

    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [IW-1:0] gnt_q, gnt_d;
    // live_q: the granted thread still wants the data of the outstanding request
    logic          live_q, live_d;
    logic [T-1:0]  req_s;
    logic          arb_valid_s;
    logic [IW-1:0] arb_idx_s;
    logic          resp_s;

    for (genvar g = 0; g < T; g++) begin : g_lane
        assign core_s[g]                 = core_state[3*g +: 3];
        assign pc_s[g]                   = current_pc[AW*g +: AW];
        assign fetcher_state[3*g +: 3]   = fstate_q[g];
        assign instruction[DW*g +: DW]   = instr_q[g];
    end

    assign mem_read_valid   = valid_q;
    assign mem_read_address = addr_q;

    rr_arbiter #(.N(T), .IW(IW)) u_arb (
        .clk         (clk),
        .rst_n       (reset),
        .req_i       (req_s),
        .en_i        (~valid_q),
        .gnt_valid_o (arb_valid_s),
        .gnt_idx_o   (arb_idx_s)
    );

    // Per-thread state machines, response capture and request issue.
    always_comb begin
        resp_s  = valid_q & mem_read_ready;
        valid_d = valid_q;
        addr_d  = addr_q;
        gnt_d   = gnt_q;
        live_d  = live_q;
        req_s   = '0;
        for (int t = 0; t < T; t++) begin
            fstate_d[t] = fstate_q[t];
            instr_d[t]  = instr_q[t];
            case (fstate_q[t])
                FETCHER_IDLE: begin
                    if (core_s[t] == CORE_FETCH) begin
                        fstate_d[t] = FETCHER_FETCHING;
                    end else begin
                        fstate_d[t] = FETCHER_IDLE;
                    end
                end
                FETCHER_FETCHING: begin
                    if (core_s[t] != CORE_FETCH) begin
                        // Abandon; an in-flight request still completes on the port.
                        fstate_d[t] = FETCHER_IDLE;
                        if (gnt_q == IW'(t)) begin
                            live_d = 1'b0;
                        end else begin
                            live_d = live_d;
                        end
                    end else if (resp_s && ((live_q && (gnt_q == IW'(t))) ||
                                            (pc_s[t] == addr_q))) begin
                        fstate_d[t] = FETCHER_FETCHED;
                        instr_d[t]  = mem_read_data;
                    end else begin
                        req_s[t] = 1'b1;
                    end
                end
                FETCHER_FETCHED: begin
                    if (core_s[t] == CORE_DECODE) begin
                        fstate_d[t] = FETCHER_IDLE;
                    end else begin
                        fstate_d[t] = FETCHER_FETCHED;
                    end
                end
                default: begin
                    fstate_d[t] = FETCHER_IDLE;
                end
            endcase
        end
        // Grant only from a fully idle port, which also forces a low cycle
        // on mem_read_valid between back-to-back requests.
        if (!valid_q) begin
            if (arb_valid_s) begin
                valid_d = 1'b1;
                addr_d  = pc_s[arb_idx_s];
                gnt_d   = arb_idx_s;
                live_d  = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end else if (resp_s) begin
            valid_d = 1'b0;
            live_d  = 1'b0;
        end else begin
            valid_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            gnt_q   <= '0;
            live_q  <= 1'b0;
            for (int t = 0; t < T; t++) begin
                fstate_q[t] <= FETCHER_IDLE;
                instr_q[t]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            gnt_q   <= gnt_d;
            live_q  <= live_d;
            for (int t = 0; t < T; t++) begin
                fstate_q[t] <= fstate_d[t];
                instr_q[t]  <= instr_d[t];
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (4 threads, 8-bit PC, 16-bit data).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] core_state;
    logic [31:0] current_pc;
    logic [11:0] fetcher_state;
    logic [63:0] instruction;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;

    int vectors     = 0;
    int miscompares = 0;

    fetch_unit #(
        .THREADS_PER_BLOCK     (4),
        .PROGRAM_MEM_ADDR_BITS (8),
        .PROGRAM_MEM_DATA_BITS (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] fs(input int t);
        return fetcher_state[3*t +: 3];
    endfunction

    function automatic logic [15:0] ins(input int t);
        return instruction[16*t +: 16];
    endfunction

    task automatic set_core(input int t, input logic [2:0] v);
        core_state[3*t +: 3] = v;
    endtask

    task automatic set_pc(input int t, input logic [7:0] v);
        current_pc[8*t +: 8] = v;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        core_state     = 12'h000;
        current_pc     = 32'h0;
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Wait (bounded) for a request, check it, hold ready low delay-1 cycles,
    // then answer with data; the request must drop on the answering edge.
    task automatic serve(input string tag, input logic [7:0] addr, input int delay,
                         input logic [15:0] data);
        int n = 0;
        while (mem_read_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {31'h0, mem_read_valid}, 32'h1);
        chk({tag, "_addr"}, {24'h0, mem_read_address}, {24'h0, addr});
        for (int k = 1; k < delay; k++) begin
            tick();
            chk({tag, "_hold_valid"}, {31'h0, mem_read_valid}, 32'h1);
            chk({tag, "_hold_addr"}, {24'h0, mem_read_address}, {24'h0, addr});
        end
        mem_read_ready = 1'b1;
        mem_read_data  = data;
        tick();
        mem_read_ready = 1'b0;
        chk({tag, "_drop"}, {31'h0, mem_read_valid}, 32'h0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        reset          = 1'b0;
        core_state     = 12'h000;
        current_pc     = 32'h0;
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0;
        #12;
        chk("rst_fstate", {20'h0, fetcher_state}, 32'h0);
        chk("rst_instr_lo", instruction[31:0], 32'h0);
        chk("rst_instr_hi", instruction[63:32], 32'h0);
        chk("rst_valid", {31'h0, mem_read_valid}, 32'h0);
        chk("rst_addr", {24'h0, mem_read_address}, 32'h0);
        do_reset();

        // ---------------- four threads, round robin, delay 2 ----------------
        for (int t = 0; t < 4; t++) begin
            set_core(t, 3'b001);
            set_pc(t, 8'h10 + 8'(t));
        end
        tick();
        chk("rr_fetching", {20'h0, fetcher_state}, 32'h249);
        chk("rr_novalid", {31'h0, mem_read_valid}, 32'h0);
        tick();
        serve("rr_g0", 8'h10, 2, 16'hA010);
        chk("rr_fs0", {29'h0, fs(0)}, 32'h2);
        chk("rr_ins0", {16'h0, ins(0)}, 32'hA010);
        tick();
        chk("rr_gap1", {31'h0, mem_read_valid}, 32'h1);
        serve("rr_g1", 8'h11, 2, 16'hA011);
        tick();
        chk("rr_gap2", {31'h0, mem_read_valid}, 32'h1);
        serve("rr_g2", 8'h12, 2, 16'hA012);
        tick();
        chk("rr_gap3", {31'h0, mem_read_valid}, 32'h1);
        serve("rr_g3", 8'h13, 2, 16'hA013);
        chk("rr_all_fetched", {20'h0, fetcher_state}, 32'h492);
        chk("rr_instr_lo", instruction[31:0], 32'hA011A010);
        chk("rr_instr_hi", instruction[63:32], 32'hA013A012);
        core_state = 12'h492;
        tick();
        chk("rr_decode_idle", {20'h0, fetcher_state}, 32'h0);
        core_state = 12'h000;

        // ---------------- single thread, minimum latency ----------------
        do_reset();
        set_core(0, 3'b001);
        set_pc(0, 8'h05);
        tick();
        chk("s_fetching", {29'h0, fs(0)}, 32'h1);
        chk("s_novalid", {31'h0, mem_read_valid}, 32'h0);
        tick();
        chk("s_valid", {31'h0, mem_read_valid}, 32'h1);
        chk("s_addr", {24'h0, mem_read_address}, 32'h05);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h1234;
        tick();
        mem_read_ready = 1'b0;
        chk("s_fetched", {29'h0, fs(0)}, 32'h2);
        chk("s_instr", {16'h0, ins(0)}, 32'h1234);
        chk("s_drop", {31'h0, mem_read_valid}, 32'h0);
        tick();
        chk("s_hold", {29'h0, fs(0)}, 32'h2);
        set_core(0, 3'b010);
        tick();
        chk("s_idle", {29'h0, fs(0)}, 32'h0);
        set_core(0, 3'b000);

        // ---------------- coalescing ----------------
        do_reset();
        core_state = 12'h249;
        current_pc = 32'h20202020;
        tick();
        tick();
        chk("c_valid", {31'h0, mem_read_valid}, 32'h1);
        chk("c_addr", {24'h0, mem_read_address}, 32'h20);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hBEEF;
        tick();
        mem_read_ready = 1'b0;
        chk("c_all_fetched", {20'h0, fetcher_state}, 32'h492);
        chk("c_instr_lo", instruction[31:0], 32'hBEEFBEEF);
        chk("c_instr_hi", instruction[63:32], 32'hBEEFBEEF);
        tick();
        chk("c_no_second_req1", {31'h0, mem_read_valid}, 32'h0);
        tick();
        chk("c_no_second_req2", {31'h0, mem_read_valid}, 32'h0);
        core_state = 12'h000;

        // ---------------- abort ----------------
        do_reset();
        set_core(1, 3'b001);
        set_pc(1, 8'h31);
        set_core(2, 3'b001);
        set_pc(2, 8'h32);
        tick();
        tick();
        chk("a_valid", {31'h0, mem_read_valid}, 32'h1);
        chk("a_addr", {24'h0, mem_read_address}, 32'h31);
        set_core(1, 3'b111);
        set_core(2, 3'b111);
        tick();
        chk("a_fs1_idle", {29'h0, fs(1)}, 32'h0);
        chk("a_fs2_idle", {29'h0, fs(2)}, 32'h0);
        chk("a_still_valid", {31'h0, mem_read_valid}, 32'h1);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hDEAD;
        tick();
        mem_read_ready = 1'b0;
        chk("a_drop", {31'h0, mem_read_valid}, 32'h0);
        chk("a_fs1_after", {29'h0, fs(1)}, 32'h0);
        chk("a_ins1_kept", {16'h0, ins(1)}, 32'h0);
        tick();
        chk("a_no_req_t2_1", {31'h0, mem_read_valid}, 32'h0);
        tick();
        chk("a_no_req_t2_2", {31'h0, mem_read_valid}, 32'h0);
        core_state = 12'h000;

        // ---------------- fairness between threads 0 and 3 ----------------
        do_reset();
        set_pc(0, 8'h40);
        set_pc(3, 8'h43);
        set_core(0, 3'b001);
        set_core(3, 3'b001);
        tick();
        tick();
        chk("f_g1_addr", {24'h0, mem_read_address}, 32'h40);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h0040;
        tick();
        chk("f_fs0_fetched", {29'h0, fs(0)}, 32'h2);
        chk("f_fs3_waiting", {29'h0, fs(3)}, 32'h1);
        mem_read_ready = 1'b0;
        set_core(0, 3'b010);
        tick();
        chk("f_g2_valid", {31'h0, mem_read_valid}, 32'h1);
        chk("f_g2_addr", {24'h0, mem_read_address}, 32'h43);
        set_core(0, 3'b001);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h0043;
        tick();
        chk("f_fs3_fetched", {29'h0, fs(3)}, 32'h2);
        chk("f_fs0_refetch", {29'h0, fs(0)}, 32'h1);
        mem_read_ready = 1'b0;
        set_core(3, 3'b010);
        tick();
        chk("f_g3_addr", {24'h0, mem_read_address}, 32'h40);
        set_core(3, 3'b001);
        mem_read_ready = 1'b1;
        tick();
        chk("f_fs0_again", {29'h0, fs(0)}, 32'h2);
        mem_read_ready = 1'b0;
        set_core(0, 3'b010);
        tick();
        chk("f_g4_addr", {24'h0, mem_read_address}, 32'h43);
        chk("f_g4_valid", {31'h0, mem_read_valid}, 32'h1);
        core_state = 12'h000;

        // ---------------- reset during a pending request ----------------
        do_reset();
        set_core(0, 3'b001);
        set_pc(0, 8'h55);
        tick();
        tick();
        chk("r_valid", {31'h0, mem_read_valid}, 32'h1);
        tick();
        reset = 1'b0;
        #1;
        chk("r_async_valid", {31'h0, mem_read_valid}, 32'h0);
        chk("r_async_addr", {24'h0, mem_read_address}, 32'h0);
        chk("r_async_fs0", {29'h0, fs(0)}, 32'h0);
        core_state = 12'h000;
        tick();
        reset = 1'b1;
        tick();
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h7777;
        tick();
        mem_read_ready = 1'b0;
        chk("r_late_valid", {31'h0, mem_read_valid}, 32'h0);
        chk("r_late_ins0", {16'h0, ins(0)}, 32'h0);
        chk("r_late_fs", {20'h0, fetcher_state}, 32'h0);
        tick();
        chk("r_late_addr", {24'h0, mem_read_address}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
